// File: rtl/secuenciador_escritura_registros.sv
// Snapshots NUM_REGS local registers on start and writes them to the RTC bus controller
// at addresses 0..NUM_REGS-1 over a req/ack handshake; pulses done, or error on timeout.
module secuenciador_escritura_registros #(
    parameter int NUM_REGS    = 10,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_start,
    input  logic [NUM_REGS*DATA_W-1:0] i_datos_locales,
    input  logic                       i_wr_ack,
    output logic [ADDR_W-1:0]          o_addr_mem_local,
    output logic [DATA_W-1:0]          o_dato_escritura,
    output logic                       o_reg_wr,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_error
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_GAP,
        S_DONE
    } state_t;

    state_t                            r_state,    w_state_nxt;
    logic [NUM_REGS-1:0][DATA_W-1:0]   r_snapshot, w_snapshot_nxt;
    logic [ADDR_W-1:0]                 r_addr,     w_addr_nxt;
    logic [DATA_W-1:0]                 r_dato,     w_dato_nxt;
    logic [CNT_W-1:0]                  r_cnt,      w_cnt_nxt;
    logic                              r_reg_wr,   w_reg_wr_nxt;
    logic                              r_busy,     w_busy_nxt;
    logic                              r_done,     w_done_nxt;
    logic                              r_error,    w_error_nxt;
    logic [ADDR_W-1:0]                 w_addr_inc;

    assign w_addr_inc = r_addr + 1'b1;

    always_comb begin
        // NOTE: every next-value gets a default before the case so no path leaves one unassigned (no latches).
        w_state_nxt    = r_state;
        w_snapshot_nxt = r_snapshot;
        w_addr_nxt     = r_addr;
        w_dato_nxt     = r_dato;
        w_cnt_nxt      = r_cnt;
        w_reg_wr_nxt   = r_reg_wr;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_error_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt    = S_REQ;
                    w_snapshot_nxt = i_datos_locales;
                    w_addr_nxt     = '0;
                    w_dato_nxt     = i_datos_locales[DATA_W-1:0];
                    w_cnt_nxt      = '0;
                    w_reg_wr_nxt   = 1'b1;
                    w_busy_nxt     = 1'b1;
                end
            end
            S_REQ: begin
                // An ack arriving on the timeout edge still completes the write.
                if (i_wr_ack) begin
                    w_reg_wr_nxt = 1'b0;
                    if (r_addr == ADDR_LAST) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_GAP;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt  = S_IDLE;
                    w_reg_wr_nxt = 1'b0;
                    w_busy_nxt   = 1'b0;
                    w_error_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_GAP: begin
                w_state_nxt  = S_REQ;
                w_addr_nxt   = w_addr_inc;
                w_dato_nxt   = r_snapshot[w_addr_inc];
                w_cnt_nxt    = '0;
                w_reg_wr_nxt = 1'b1;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_reg_wr_nxt = 1'b0;
                w_busy_nxt   = 1'b0;
            end
        endcase
    end

    // NOTE: the snapshot is plain flops, not a RAM, so it is cleared by reset like the rest.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_snapshot <= '0;
            r_addr     <= '0;
            r_dato     <= '0;
            r_cnt      <= '0;
            r_reg_wr   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            r_state    <= w_state_nxt;
            r_snapshot <= w_snapshot_nxt;
            r_addr     <= w_addr_nxt;
            r_dato     <= w_dato_nxt;
            r_cnt      <= w_cnt_nxt;
            r_reg_wr   <= w_reg_wr_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
        end
    end

    assign o_addr_mem_local = r_addr;
    assign o_dato_escritura = r_dato;
    assign o_reg_wr         = r_reg_wr;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_error          = r_error;

endmodule

// File: tb/tb_secuenciador_escritura_registros.sv
// Bench for the register write sequencer: an ack responder plus a write log checked
// against the expected list of (address, snapshot byte) pairs.
module tb_secuenciador_escritura_registros;

    localparam int NUM_REGS    = 10;
    localparam int DATA_W      = 8;
    localparam int ADDR_W      = 4;
    localparam int TIMEOUT_CYC = 255;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    logic                       i_clk = 1'b0;
    logic                       i_reset;
    logic                       i_start;
    logic [NUM_REGS*DATA_W-1:0] i_datos_locales;
    logic                       i_wr_ack;
    logic [ADDR_W-1:0]          o_addr_mem_local;
    logic [DATA_W-1:0]          o_dato_escritura;
    logic                       o_reg_wr;
    logic                       o_busy;
    logic                       o_done;
    logic                       o_error;

    int n_vec = 0;
    int n_err = 0;

    // responder configuration and write log
    bit  ack_en   = 1'b1;
    int  dly_addr = -1;
    int  dly_cyc  = 0;
    int  wait_cnt = 0;
    wr_t wq[$];
    int  hold_len[16];
    logic [DATA_W-1:0] snap[NUM_REGS];

    logic              prev_wr   = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [DATA_W-1:0] prev_dato = '0;

    secuenciador_escritura_registros #(
        .NUM_REGS   (NUM_REGS),
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_start         (i_start),
        .i_datos_locales (i_datos_locales),
        .i_wr_ack        (i_wr_ack),
        .o_addr_mem_local(o_addr_mem_local),
        .o_dato_escritura(o_dato_escritura),
        .o_reg_wr        (o_reg_wr),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_error         (o_error)
    );

    always #5 i_clk = ~i_clk;

    // Responder: answers a pending request combinationally (or after a programmed wait at one
    // address) and logs every write that will be accepted at the next rising edge.
    always @(negedge i_clk) begin
        if (o_reg_wr) begin
            if (prev_wr) begin
                n_vec++;
                if (o_addr_mem_local !== prev_addr || o_dato_escritura !== prev_dato) begin
                    n_err++;
                    $display("FAIL hold_stable: addr/data %0d/%h, required %0d/%h",
                             o_addr_mem_local, o_dato_escritura, prev_addr, prev_dato);
                end
            end
            hold_len[o_addr_mem_local]++;
            if (!ack_en) begin
                i_wr_ack = 1'b0;
            end else if (int'(o_addr_mem_local) == dly_addr && wait_cnt < dly_cyc) begin
                wait_cnt++;
                i_wr_ack = 1'b0;
            end else begin
                i_wr_ack = 1'b1;
            end
            if (i_wr_ack) wq.push_back('{a: o_addr_mem_local, d: o_dato_escritura});
        end else begin
            wait_cnt = 0;
            i_wr_ack = 1'b0;
        end
        prev_wr   = o_reg_wr;
        prev_addr = o_addr_mem_local;
        prev_dato = o_dato_escritura;
    end

    task automatic load_data(input bit rnd);
        for (int k = 0; k < NUM_REGS; k++) begin
            snap[k] = rnd ? DATA_W'($urandom_range(0, 255)) : DATA_W'(8'h10 + k);
            i_datos_locales[k*DATA_W +: DATA_W] = snap[k];
        end
    endtask

    task automatic clear_log();
        wq.delete();
        for (int k = 0; k < 16; k++) hold_len[k] = 0;
    endtask

    // Launches one start pulse (unless keep_start) and waits for done or error.
    task automatic run_seq(input int budget, input bit keep_start,
                           output int cyc, output bit d, output bit e);
        d = 1'b0;
        e = 1'b0;
        cyc = 0;
        i_start = 1'b1;
        while (!d && !e && cyc < budget) begin
            @(negedge i_clk);
            cyc++;
            if (!keep_start) i_start = 1'b0;
            d = o_done;
            e = o_error;
        end
    endtask

    task automatic check_writes(input string tag);
        n_vec++;
        if (wq.size() != NUM_REGS) begin
            n_err++;
            $display("FAIL %s_count: %0d writes, required %0d", tag, wq.size(), NUM_REGS);
        end
        for (int k = 0; k < NUM_REGS && k < wq.size(); k++) begin
            n_vec++;
            if (wq[k].a !== ADDR_W'(k) || wq[k].d !== snap[k]) begin
                n_err++;
                $display("FAIL %s_write%0d: (%0d,%h), required (%0d,%h)",
                         tag, k, wq[k].a, wq[k].d, k, snap[k]);
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        n_vec++;
        if ({o_addr_mem_local, o_dato_escritura, o_reg_wr, o_busy, o_done, o_error} !== '0) begin
            n_err++;
            $display("FAIL %s: addr=%0d dato=%h reg_wr=%b busy=%b done=%b error=%b, required all 0",
                     tag, o_addr_mem_local, o_dato_escritura, o_reg_wr, o_busy, o_done, o_error);
        end
    endtask

    task automatic check_seq_end(input string tag, input int cyc, input int exp_cyc,
                                 input bit d, input bit e);
        n_vec++;
        if (!d || e || cyc != exp_cyc) begin
            n_err++;
            $display("FAIL %s_done: done=%b error=%b after %0d cycles, required done=1 error=0 after %0d",
                     tag, d, e, cyc, exp_cyc);
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        i_start = 1'b0;
        i_wr_ack = 1'b0;
        i_datos_locales = '0;
        #1;
        check_outputs_zero("reset_state");
        repeat (3) @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        check_outputs_zero("idle_after_reset");
    endtask

    task automatic test_basic(input bit rnd);
        int cyc;
        bit d, e;
        load_data(rnd);
        clear_log();
        run_seq(100, 1'b0, cyc, d, e);
        check_seq_end("basic", cyc, 2 * NUM_REGS, d, e);
        check_writes("basic");
        @(negedge i_clk);
        n_vec++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_pulse: done=%b busy=%b, required 0/0", o_done, o_busy);
        end
    endtask

    task automatic test_ack_delay();
        int cyc;
        bit d, e;
        load_data(1'b0);
        clear_log();
        dly_addr = 3;
        dly_cyc  = 5;
        run_seq(100, 1'b0, cyc, d, e);
        dly_addr = -1;
        check_seq_end("ack_delay", cyc, 2 * NUM_REGS + 5, d, e);
        check_writes("ack_delay");
        for (int k = 0; k < NUM_REGS; k++) begin
            n_vec++;
            if (hold_len[k] != ((k == 3) ? 6 : 1)) begin
                n_err++;
                $display("FAIL ack_delay_hold%0d: reg_wr high %0d cycles, required %0d",
                         k, hold_len[k], (k == 3) ? 6 : 1);
            end
        end
        @(negedge i_clk);
    endtask

    task automatic test_timeout();
        int cyc;
        bit d, e;
        load_data(1'b1);
        clear_log();
        ack_en = 1'b0;
        run_seq(400, 1'b0, cyc, d, e);
        n_vec++;
        if (!e || d || cyc != TIMEOUT_CYC + 1) begin
            n_err++;
            $display("FAIL timeout_error: error=%b done=%b after %0d cycles, required 1/0 after %0d",
                     e, d, cyc, TIMEOUT_CYC + 1);
        end
        n_vec++;
        if (o_busy !== 1'b0 || o_reg_wr !== 1'b0 || o_done !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_outputs: busy=%b reg_wr=%b done=%b, required 0/0/0",
                     o_busy, o_reg_wr, o_done);
        end
        n_vec++;
        if (hold_len[0] != TIMEOUT_CYC || wq.size() != 0) begin
            n_err++;
            $display("FAIL timeout_hold: addr0 held %0d cycles with %0d writes, required %0d with 0",
                     hold_len[0], wq.size(), TIMEOUT_CYC);
        end
        @(negedge i_clk);
        n_vec++;
        if (o_error !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_pulse: error=%b, required 0", o_error);
        end
        ack_en = 1'b1;
    endtask

    task automatic test_snapshot();
        int cyc;
        bit d, e;
        load_data(1'b1);
        clear_log();
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        cyc = 1;
        while (o_addr_mem_local != 4 && cyc < 50) begin
            @(negedge i_clk);
            cyc++;
        end
        i_datos_locales = '1;
        i_start = 1'b1;
        @(negedge i_clk);
        cyc++;
        i_start = 1'b0;
        d = o_done;
        e = o_error;
        while (!d && !e && cyc < 100) begin
            @(negedge i_clk);
            cyc++;
            d = o_done;
            e = o_error;
        end
        check_seq_end("snapshot", cyc, 2 * NUM_REGS, d, e);
        check_writes("snapshot");
        repeat (3) @(negedge i_clk);
        n_vec++;
        if (o_busy !== 1'b0 || o_reg_wr !== 1'b0) begin
            n_err++;
            $display("FAIL snapshot_restart: busy=%b reg_wr=%b, required 0/0", o_busy, o_reg_wr);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit d, e;
        load_data(1'b1);
        clear_log();
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        cyc = 1;
        while (!(o_addr_mem_local == 6 && o_reg_wr) && cyc < 50) begin
            @(negedge i_clk);
            cyc++;
        end
        n_vec++;
        if (o_addr_mem_local !== 4'd6) begin
            n_err++;
            $display("FAIL reset_mid_reach: addr=%0d, required 6", o_addr_mem_local);
        end
        #2 i_reset = 1'b0;
        #1;
        check_outputs_zero("reset_mid_async");
        @(negedge i_clk);
        check_outputs_zero("reset_mid_held");
        i_reset = 1'b1;
        @(negedge i_clk);
        check_outputs_zero("reset_mid_no_pulse");
        load_data(1'b1);
        clear_log();
        run_seq(100, 1'b0, cyc, d, e);
        check_seq_end("reset_mid_rerun", cyc, 2 * NUM_REGS, d, e);
        check_writes("reset_mid_rerun");
        @(negedge i_clk);
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit d, e;
        load_data(1'b1);
        clear_log();
        run_seq(100, 1'b1, cyc, d, e);
        check_seq_end("b2b_first", cyc, 2 * NUM_REGS, d, e);
        check_writes("b2b_first");
        clear_log();
        @(negedge i_clk);
        n_vec++;
        if (o_busy !== 1'b0 || o_reg_wr !== 1'b0 || o_done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle: busy=%b reg_wr=%b done=%b, required 0/0/0",
                     o_busy, o_reg_wr, o_done);
        end
        @(negedge i_clk);
        n_vec++;
        if (o_reg_wr !== 1'b1 || o_busy !== 1'b1 || o_addr_mem_local !== '0) begin
            n_err++;
            $display("FAIL b2b_restart: reg_wr=%b busy=%b addr=%0d, required 1/1/0",
                     o_reg_wr, o_busy, o_addr_mem_local);
        end
        cyc = 1;
        d = o_done;
        e = o_error;
        while (!d && !e && cyc < 100) begin
            @(negedge i_clk);
            cyc++;
            d = o_done;
            e = o_error;
        end
        i_start = 1'b0;
        check_seq_end("b2b_second", cyc, 2 * NUM_REGS, d, e);
        check_writes("b2b_second");
        repeat (3) @(negedge i_clk);
    endtask

    initial begin
        test_reset();
        test_basic(1'b0);
        test_basic(1'b1);
        test_ack_delay();
        test_timeout();
        test_snapshot();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
